// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (quotient to LO, remainder to HI)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] dvd_raw;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   diff;

    always_comb begin
        a_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
        // rem < dsr always holds, so ext - dsr fits in WIDTH+1 bits and diff[WIDTH] is a true sign
        ext   = {rem, quo[WIDTH-1]};
        diff  = ext - {1'b0, dsr};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            sgn         <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            dvd_raw     <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn         <= sign;
                        a_neg       <= dividend[WIDTH-1];
                        b_neg       <= divisor[WIDTH-1];
                        quo         <= a_mag;
                        dsr         <= b_mag;
                        dvd_raw     <= dividend;
                        rem         <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (divisor == '0) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    rem <= diff[WIDTH] ? ext[WIDTH-1:0] : diff[WIDTH-1:0];
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    if (dsr == '0) begin
                        q           <= '1;
                        r           <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        q <= (sgn && (a_neg ^ b_neg)) ? -quo : quo;
                        r <= (sgn && a_neg) ? -rem : rem;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
